// File: rtl/dds_tx_pkg.sv
// Purpose: shared types and helpers for the DDS sample UART streamer.
// Latency: n/a (types, constant helpers and a pure parity function).
// Backpressure: n/a.
package dds_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Widest data word the parity helper accepts; callers zero-extend.
    localparam int MAX_DATA_W = 32;

    // Bits needed for a counter that runs 0..max_val (never less than one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Parity bit for a frame: XOR of the data bits, inverted for odd parity.
    function automatic logic par_bit(input logic [MAX_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Purpose: small synchronous FIFO with registered occupancy.
// Latency: a push is visible at dout/level one clk after the pushing edge.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
// Ports: clk/rst_n; push+din write side; pop+dout read side (dout is show-ahead);
//        full/empty/level status, all derived from the registered occupancy.
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Depth is a power of two, so pointers wrap by natural overflow.
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/dds_sample_uart_tx.sv
// Purpose: decimate DDS samples, buffer the upper DATA_W bits, send each as a UART frame.
// Latency: capture on edge E0, tx falls on E1 when idle; frames run back to back.
// Backpressure: none upstream; captures arriving with a full FIFO are dropped and flagged.
// Ports: clk/rst_n; enable gates captures; sample_in/sample_valid sample stream;
//        clear_overflow clears the sticky drop flag; tx serial line (idle high);
//        busy frame on line; fifo_level occupancy; overflow sticky drop flag.
module dds_sample_uart_tx
    import dds_tx_pkg::*;
#(
    parameter int SAMPLE_W     = 12,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 12,
    parameter int DECIM        = 10,
    parameter int STOP_BITS    = 2,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [SAMPLE_W-1:0]             sample_in,
    input  logic                            sample_valid,
    input  logic                            clear_overflow,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            overflow
);

    localparam int BAUD_MAX = STOP_BITS * CLKS_PER_BIT - 1;
    localparam int BAUD_W   = cnt_w(BAUD_MAX);
    localparam int DEC_W    = cnt_w(DECIM - 1);
    localparam int BIT_W    = cnt_w(DATA_W - 1);

    // ---------------- decimator ----------------
    logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
    logic             cap_push;

    always_comb begin
        dec_cnt_d = dec_cnt_q;
        cap_push  = 1'b0;
        if (!enable) begin
            dec_cnt_d = '0;
        end else if (sample_valid) begin
            if (dec_cnt_q == DEC_W'(DECIM - 1)) begin
                cap_push  = 1'b1;
                dec_cnt_d = '0;
            end else begin
                dec_cnt_d = dec_cnt_q + DEC_W'(1);
            end
        end
    end

    // Lower sample bits are intentionally discarded.
    logic sample_lsb_unused;
    assign sample_lsb_unused = ^sample_in;

    // ---------------- sample FIFO ----------------
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    sample_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap_push),
        .din   (sample_in[SAMPLE_W-1 -: DATA_W]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // ---------------- overflow flag ----------------
    logic overflow_q, overflow_d;
    logic cap_drop;

    assign cap_drop = cap_push && fifo_full && !fifo_pop;

    always_comb begin
        overflow_d = overflow_q;
        if (clear_overflow) overflow_d = 1'b0;
        if (cap_drop)       overflow_d = 1'b1;   // a drop beats a same-cycle clear
    end

    // ---------------- TX FSM ----------------
    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] shift_nxt;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              bit_done;
    logic              stop_done;
    logic              start_frame;

    assign bit_done  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign stop_done = (baud_q == BAUD_W'(BAUD_MAX));
    assign shift_nxt = shift_q >> 1;

    // tx_d is the line level for the state being entered, so tx leaves a flop.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = tx_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) start_frame = 1'b1;
            end
            START: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_idx_q == BIT_W'(DATA_W - 1)) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        shift_d   = shift_nxt;
                        tx_d      = shift_nxt[0];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            PARITY: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (stop_done) begin
                    baud_d = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (start_frame) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            par_d    = par_bit(MAX_DATA_W'(fifo_dout), PARITY_ODD != 0);
            state_d  = START;
            baud_d   = '0;
            tx_d     = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt_q  <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            dec_cnt_q  <= dec_cnt_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_dds_sample_uart_tx.sv
// Purpose: randomized + directed bench for dds_sample_uart_tx against a frame-level model.
// Latency: model and DUTs advance on the same rising edge; outputs compared on the falling edge.
// Backpressure: n/a (bench drives free-running strobes).
module tb_dds_sample_uart_tx;

    // Instance A: default configuration. Instance B: parity (odd), DECIM=1, depth 2.
    localparam int A_CPB = 12, A_DEC = 10, A_STOP = 2, A_PEN = 0, A_PODD = 0, A_DEPTH = 4;
    localparam int B_CPB = 3,  B_DEC = 1,  B_STOP = 1, B_PEN = 1, B_PODD = 1, B_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [11:0] sample_in = '0;

    logic       tx_a, busy_a, ovf_a;
    logic [2:0] lvl_a;
    logic       tx_b, busy_b, ovf_b;
    logic [1:0] lvl_b;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dds_sample_uart_tx u_dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .clear_overflow (clear_overflow),
        .tx             (tx_a),
        .busy           (busy_a),
        .fifo_level     (lvl_a),
        .overflow       (ovf_a)
    );

    dds_sample_uart_tx #(
        .CLKS_PER_BIT (B_CPB),
        .DECIM        (B_DEC),
        .STOP_BITS    (B_STOP),
        .PARITY_EN    (B_PEN),
        .PARITY_ODD   (B_PODD),
        .FIFO_DEPTH   (B_DEPTH)
    ) u_dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .clear_overflow (clear_overflow),
        .tx             (tx_b),
        .busy           (busy_b),
        .fifo_level     (lvl_b),
        .overflow       (ovf_b)
    );

    // ---------------- reference model ----------------
    function automatic int p_cpb(input int i);   return (i == 0) ? A_CPB   : B_CPB;   endfunction
    function automatic int p_dec(input int i);   return (i == 0) ? A_DEC   : B_DEC;   endfunction
    function automatic int p_stop(input int i);  return (i == 0) ? A_STOP  : B_STOP;  endfunction
    function automatic int p_pen(input int i);   return (i == 0) ? A_PEN   : B_PEN;   endfunction
    function automatic int p_podd(input int i);  return (i == 0) ? A_PODD  : B_PODD;  endfunction
    function automatic int p_depth(input int i); return (i == 0) ? A_DEPTH : B_DEPTH; endfunction
    function automatic int flen(input int i);
        return (1 + 8 + p_pen(i) + p_stop(i)) * p_cpb(i);
    endfunction

    int         m_dec [2];
    int         m_pos [2];      // cycle index within current frame, -1 when idle
    int         m_cnt [2];      // entries waiting in the buffer
    int         m_ovf [2];
    logic [7:0] m_q   [2][8];   // waiting entries, oldest at index 0
    int         m_bits[2][16];  // line level for each bit slot of the current frame

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_dec[i] = 0;
            m_pos[i] = -1;
            m_cnt[i] = 0;
            m_ovf[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        bit         full_now, pop_now, push_now;
        logic [7:0] byt;
        int         n;
        full_now = (m_cnt[i] == p_depth(i));
        pop_now  = (m_pos[i] < 0 || m_pos[i] == flen(i) - 1) && (m_cnt[i] > 0);
        push_now = enable && sample_valid && (m_dec[i] == p_dec(i) - 1);
        if (pop_now) begin
            byt = m_q[i][0];
            for (int k = 0; k < 7; k++) m_q[i][k] = m_q[i][k+1];
            m_cnt[i]--;
            m_bits[i][0] = 0;
            for (int b = 0; b < 8; b++) m_bits[i][1+b] = int'(byt[b]);
            n = 9;
            if (p_pen(i) != 0) begin
                m_bits[i][n] = ($countones(byt) + p_podd(i)) % 2;
                n++;
            end
            for (int s = 0; s < p_stop(i); s++) begin
                m_bits[i][n] = 1;
                n++;
            end
            m_pos[i] = 0;
        end else if (m_pos[i] == flen(i) - 1) begin
            m_pos[i] = -1;
        end else if (m_pos[i] >= 0) begin
            m_pos[i]++;
        end
        if (push_now && full_now && !pop_now) begin
            m_ovf[i] = 1;
        end else begin
            if (push_now) begin
                m_q[i][m_cnt[i]] = sample_in[11:4];
                m_cnt[i]++;
            end
            if (clear_overflow) m_ovf[i] = 0;
        end
        if (!enable)           m_dec[i] = 0;
        else if (sample_valid) m_dec[i] = (m_dec[i] == p_dec(i) - 1) ? 0 : m_dec[i] + 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    function automatic int exp_tx(input int i);
        return (m_pos[i] < 0) ? 1 : m_bits[i][m_pos[i] / p_cpb(i)];
    endfunction

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    task automatic cmp_all();
        check_val("tx_a",   int'(tx_a),   exp_tx(0));
        check_val("busy_a", int'(busy_a), int'(m_pos[0] >= 0));
        check_val("lvl_a",  int'(lvl_a),  m_cnt[0]);
        check_val("ovf_a",  int'(ovf_a),  m_ovf[0]);
        check_val("tx_b",   int'(tx_b),   exp_tx(1));
        check_val("busy_b", int'(busy_b), int'(m_pos[1] >= 0));
        check_val("lvl_b",  int'(lvl_b),  m_cnt[1]);
        check_val("ovf_b",  int'(ovf_b),  m_ovf[1]);
    endtask

    // Drive inputs for the next rising edge, then compare after it (on the falling edge).
    task automatic step(input bit en, input bit sv, input logic [11:0] s, input bit clr);
        enable         = en;
        sample_valid   = sv;
        sample_in      = s;
        clear_overflow = clr;
        @(negedge clk);
        cmp_all();
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_tx"},   int'(tx_a),   1);
        check_val({tag, "_busy"}, int'(busy_a), 0);
        check_val({tag, "_lvl"},  int'(lvl_a),  0);
        check_val({tag, "_ovf"},  int'(ovf_a),  0);
        check_val({tag, "_txb"},  int'(tx_b),   1);
        check_val({tag, "_lvlb"}, int'(lvl_b),  0);
    endtask

    logic        tx_tr [160];
    logic [10:0] pat;

    initial begin
        int busy_cnt;
        int rise;

        // ---- reset ----
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_hold");
        rst_n = 1'b1;
        repeat (5) step(1'b0, 1'b0, 12'h000, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_idle");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 12'h000, 1'b0);

        // ---- single frame of 0xA5 ----
        for (int k = 0; k < 10; k++)
            step(1'b1, 1'b1, (k == 9) ? 12'hA5C : 12'($urandom), 1'b0);
        busy_cnt = 0;
        rise     = -1;
        for (int k = 0; k < 160; k++) begin
            step(1'b1, 1'b0, 12'($urandom), 1'b0);
            tx_tr[k] = tx_a;
            if (busy_a) begin
                busy_cnt++;
                if (rise < 0) rise = k;
            end
        end
        check_val("busy_len", busy_cnt, 132);
        check_val("start_lat", rise, 0);
        pat = 11'b11101001010;   // start, A5 LSB first, two stops
        if (rise >= 0 && rise <= 20) begin
            for (int j = 0; j < 11; j++)
                check_val("frame_bit", int'(tx_tr[rise + 12*j + 6]), int'(pat[j]));
        end

        // ---- continuous strobes: back-to-back frames and overflow ----
        for (int k = 1; k <= 90; k++) begin
            step(1'b1, 1'b1, 12'($urandom), k == 75);
            if (k == 70) begin
                check_val("lvl_full", int'(lvl_a), 4);
                check_val("ovf_set",  int'(ovf_a), 1);
            end
            if (k == 75) check_val("ovf_clr",  int'(ovf_a), 0);
            if (k == 80) check_val("ovf_again", int'(ovf_a), 1);
        end
        repeat (700) step(1'b0, 1'b0, 12'($urandom), 1'b0);

        // ---- randomized traffic ----
        for (int k = 0; k < 1500; k++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                 12'($urandom), $urandom_range(0, 31) == 0);
        repeat (700) step(1'b0, 1'b0, 12'($urandom), 1'b0);

        // ---- enable gating ----
        for (int k = 0; k < 25; k++) step(1'b0, 1'b1, 12'($urandom), 1'b0);
        check_val("gate_lvl",  int'(lvl_a),  0);
        check_val("gate_busy", int'(busy_a), 0);
        for (int k = 0; k < 9; k++) step(1'b1, 1'b1, 12'($urandom), 1'b0);
        check_val("pre10_lvl", int'(lvl_a), 0);
        step(1'b1, 1'b1, 12'hA50, 1'b0);
        check_val("cap10_lvl", int'(lvl_a), 1);

        // ---- asynchronous reset during data bit 3 (0 for 0xA5) ----
        repeat (53) step(1'b0, 1'b1, 12'($urandom), 1'b0);
        check_val("pre_rst_tx", int'(tx_a), 0);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_tx",   int'(tx_a),   1);
        check_val("arst_busy", int'(busy_a), 0);
        check_val("arst_lvl",  int'(lvl_a),  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step(1'b0, 1'b0, 12'($urandom), 1'b0);
        check_val("post_rst_tx",  int'(tx_a),  1);
        check_val("post_rst_lvl", int'(lvl_a), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
